// File: rtl/fd_pkg.sv
// Shared constants, FSM state encoding and window base-address helper for detection_scheduler.
package fd_pkg;

    localparam int FD_II_WIDTH  = 160;
    localparam int FD_II_HEIGHT = 120;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam logic [5:0] ST_IDLE     = 6'b000001;
    localparam logic [5:0] ST_LAUNCH   = 6'b000010;
    localparam logic [5:0] ST_WAIT     = 6'b000100;
    localparam logic [5:0] ST_NEXT_STG = 6'b001000;
    localparam logic [5:0] ST_NEXT_WIN = 6'b010000;
    localparam logic [5:0] ST_DONE     = 6'b100000;

    typedef enum logic [5:0] {
        S_IDLE     = ST_IDLE,
        S_LAUNCH   = ST_LAUNCH,
        S_WAIT     = ST_WAIT,
        S_NEXT_STG = ST_NEXT_STG,
        S_NEXT_WIN = ST_NEXT_WIN,
        S_DONE     = ST_DONE
    } fd_state_e;

    function automatic logic [31:0] fd_base_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y,
                                                 input int             width);
        return 32'(y) * 32'(width) + 32'(x);
    endfunction

endpackage

// File: rtl/fd_rd_addr_mux.sv
// Selects the active stage's buffer read address; drives 0 whenever no stage owns the port.
module fd_rd_addr_mux
    import fd_pkg::*;
#(
    parameter int NUM_CLS = 2,
    parameter int ADDR_W  = 15,
    parameter int SEL_W   = 1
)(
    input  logic                      en,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_CLS*ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0]         addr_out
);

    always_comb begin
        addr_out = '0;
        if (en) begin
            for (int i = 0; i < NUM_CLS; i++) begin
                if (sel == SEL_W'(i)) begin
                    addr_out = addr_in[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

endmodule

// File: rtl/detection_scheduler.sv
// Raster-sweeps the detection window over the integral image and runs the Haar cascade per window.
// FD_EARLY_REJECT_EN: a failing stage skips the remaining stages of that window.
//   state    | meaning
//   IDLE     | waiting for frame_ready
//   LAUNCH   | start pulse to the current stage
//   WAIT     | stage owns the buffer port; wait for done or timeout
//   NEXT_STG | next stage, hit report, or window advance
//   NEXT_WIN | step window position, reload stage 0
//   DONE     | frame_done pulse, drop busy
module detection_scheduler
    import fd_pkg::*;
#(
    parameter int II_WIDTH  = FD_II_WIDTH,
    parameter int II_HEIGHT = FD_II_HEIGHT,
    parameter int WIN_W     = 24,
    parameter int WIN_H     = 24,
    parameter int STEP      = 4,
    parameter int NUM_CLS   = 2,
    parameter int ADDR_W    = 15,
    parameter int TIMEOUT   = 255
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_ready,
    output logic                      busy,
    output logic                      frame_done,
    output logic [NUM_CLS-1:0]        cls_start,
    input  logic [NUM_CLS-1:0]        cls_done,
    input  logic [NUM_CLS-1:0]        cls_flag,
    input  logic [NUM_CLS*ADDR_W-1:0] cls_rd_addr,
    output logic [ADDR_W-1:0]         buf_rd_addr,
    output logic [ADDR_W-1:0]         win_base,
    output logic                      hit_valid,
    output logic [7:0]                hit_x,
    output logic [6:0]                hit_y,
    output logic [15:0]               hit_count,
    output logic                      timeout_err
);

    localparam int STG_W = (NUM_CLS > 1) ? $clog2(NUM_CLS) : 1;
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int XA_W  = X_W + 1;
    localparam int YA_W  = Y_W + 1;
    localparam logic [XA_W-1:0] X_LAST = XA_W'(II_WIDTH - WIN_W);
    localparam logic [YA_W-1:0] Y_LAST = YA_W'(II_HEIGHT - WIN_H);

    fd_state_e            state_q, state_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [STG_W-1:0]     stage_q, stage_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 pass_q, pass_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic [NUM_CLS-1:0]   cls_start_q, cls_start_d;
    logic [ADDR_W-1:0]    win_base_q, win_base_d;
    logic                 hit_valid_q, hit_valid_d;
    logic [X_W-1:0]       hit_x_q, hit_x_d;
    logic [Y_W-1:0]       hit_y_q, hit_y_d;
    logic [15:0]          hit_count_q, hit_count_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 done_sel, flag_sel, last_stg, win_end, in_wait;
    logic [XA_W-1:0]      x_adv;
    logic [YA_W-1:0]      y_adv;

    assign in_wait = (state_q == S_WAIT);

    fd_rd_addr_mux #(
        .NUM_CLS (NUM_CLS),
        .ADDR_W  (ADDR_W),
        .SEL_W   (STG_W)
    ) u_rd_mux (
        .en       (in_wait),
        .sel      (stage_q),
        .addr_in  (cls_rd_addr),
        .addr_out (buf_rd_addr)
    );

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        stage_d       = stage_q;
        tmr_d         = tmr_q;
        pass_d        = pass_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        cls_start_d   = '0;
        win_base_d    = win_base_q;
        hit_valid_d   = 1'b0;
        hit_x_d       = hit_x_q;
        hit_y_d       = hit_y_q;
        hit_count_d   = hit_count_q;
        timeout_err_d = timeout_err_q;
        done_sel      = 1'b0;
        flag_sel      = 1'b0;
        win_end       = 1'b0;

        // Only the running stage's done/flag are visible; other stages' pulses are ignored.
        for (int i = 0; i < NUM_CLS; i++) begin
            if (stage_q == STG_W'(i)) begin
                done_sel = cls_done[i];
                flag_sel = cls_flag[i];
            end
        end
        last_stg = (stage_q == STG_W'(NUM_CLS - 1));
        x_adv    = {1'b0, x_q} + XA_W'(STEP);
        y_adv    = {1'b0, y_q} + YA_W'(STEP);

        unique case (state_q)
            S_IDLE: begin
                if (frame_ready) begin
                    state_d       = S_LAUNCH;
                    busy_d        = 1'b1;
                    hit_count_d   = '0;
                    timeout_err_d = 1'b0;
                    x_d           = '0;
                    y_d           = '0;
                    stage_d       = '0;
                    win_base_d    = '0;
                    pass_d        = 1'b1;
                end
            end
            S_LAUNCH: begin
                for (int i = 0; i < NUM_CLS; i++) begin
                    cls_start_d[i] = (stage_q == STG_W'(i));
                end
                tmr_d   = TMR_W'(TIMEOUT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_sel) begin
                    pass_d  = pass_q & flag_sel;
                    state_d = S_NEXT_STG;
                end else if (tmr_q == '0) begin
                    pass_d        = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = S_NEXT_STG;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_NEXT_STG: begin
`ifdef FD_EARLY_REJECT_EN
                win_end = last_stg || !pass_q;
`else
                win_end = last_stg;
`endif
                if (win_end) begin
                    state_d = S_NEXT_WIN;
                    if (last_stg && pass_q) begin
                        hit_valid_d = 1'b1;
                        hit_x_d     = x_q;
                        hit_y_d     = y_q;
                        if (hit_count_q != 16'hFFFF) begin
                            hit_count_d = hit_count_q + 16'd1;
                        end
                    end
                end else begin
                    stage_d = stage_q + STG_W'(1);
                    state_d = S_LAUNCH;
                end
            end
            S_NEXT_WIN: begin
                stage_d = '0;
                pass_d  = 1'b1;
                state_d = S_LAUNCH;
                if (x_adv <= X_LAST) begin
                    x_d = x_adv[X_W-1:0];
                end else begin
                    x_d = '0;
                    if (y_adv <= Y_LAST) begin
                        y_d = y_adv[Y_W-1:0];
                    end else begin
                        state_d = S_DONE;
                    end
                end
                win_base_d = ADDR_W'(fd_base_addr(x_d, y_d, II_WIDTH));
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            stage_q       <= '0;
            tmr_q         <= '0;
            pass_q        <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            cls_start_q   <= '0;
            win_base_q    <= '0;
            hit_valid_q   <= 1'b0;
            hit_x_q       <= '0;
            hit_y_q       <= '0;
            hit_count_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            stage_q       <= stage_d;
            tmr_q         <= tmr_d;
            pass_q        <= pass_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            cls_start_q   <= cls_start_d;
            win_base_q    <= win_base_d;
            hit_valid_q   <= hit_valid_d;
            hit_x_q       <= hit_x_d;
            hit_y_q       <= hit_y_d;
            hit_count_q   <= hit_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign cls_start   = cls_start_q;
    assign win_base    = win_base_q;
    assign hit_valid   = hit_valid_q;
    assign hit_x       = hit_x_q;
    assign hit_y       = hit_y_q;
    assign hit_count   = hit_count_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_detection_scheduler.sv
// Bench for detection_scheduler: reactive classifier stubs plus a window-list reference model.
`timescale 1ns/1ps
module tb_detection_scheduler;

    localparam int NUM_CLS = 2;
    localparam int ADDR_W  = 15;
    localparam int NXP     = 35;
    localparam int NYP     = 25;
    localparam int NW      = NXP * NYP;
    localparam int BUDGET  = 60000;
`ifdef FD_EARLY_REJECT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      frame_ready;
    logic                      busy, frame_done;
    logic [NUM_CLS-1:0]        cls_start, cls_done, cls_flag;
    logic [NUM_CLS*ADDR_W-1:0] cls_rd_addr;
    logic [ADDR_W-1:0]         buf_rd_addr, win_base;
    logic                      hit_valid;
    logic [7:0]                hit_x;
    logic [6:0]                hit_y;
    logic [15:0]               hit_count;
    logic                      timeout_err;

    always #5 clk = ~clk;

    detection_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .frame_ready (frame_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .cls_start   (cls_start),
        .cls_done    (cls_done),
        .cls_flag    (cls_flag),
        .cls_rd_addr (cls_rd_addr),
        .buf_rd_addr (buf_rd_addr),
        .win_base    (win_base),
        .hit_valid   (hit_valid),
        .hit_x       (hit_x),
        .hit_y       (hit_y),
        .hit_count   (hit_count),
        .timeout_err (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    // stub configuration and observation state
    bit flag_tbl [NUM_CLS][NW];
    int sil_w = -1, sil_s = 0;
    int dly_lo = 1, dly_hi = 1;
    bit spur_en = 1'b0;
    int widx = 0;
    bit act_on = 1'b0, act_sil = 1'b0, act_flag = 1'b0;
    int act_s = 0, wcnt = 0, act_d = 1;
    int n_start0 = 0, n_start1 = 0, n_fd = 0;
    int order_err = 0, buf_err = 0, proto_err = 0, hit_wb_err = 0;
    int obs_hx[$], obs_hy[$], obs_wb[$];

    function automatic int wx(input int k); return (k % NXP) * 4; endfunction
    function automatic int wy(input int k); return (k / NXP) * 4; endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Classifier stubs and monitor: outputs sampled and inputs driven on the falling edge.
    initial begin : stub
        logic [ADDR_W-1:0] exp_buf;
        bit act_end;
        int cur_w;
        cls_done = '0; cls_flag = '0; cls_rd_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act_on = 1'b0;
                cls_done = '0;
                cls_flag = '0;
                cls_rd_addr = (NUM_CLS*ADDR_W)'($urandom);
            end else begin
                if ($countones(cls_start) > 1) proto_err++;
                for (int s = 0; s < NUM_CLS; s++) begin
                    if (cls_start[s]) begin
                        if (act_on) proto_err++;
                        if (s == 0) begin
                            n_start0++;
                            if (widx >= NW || int'(win_base) != wy(widx) * 160 + wx(widx)) order_err++;
                            widx++;
                        end else begin
                            n_start1++;
                        end
                        cur_w    = widx - 1;
                        act_on   = 1'b1;
                        act_s    = s;
                        wcnt     = 0;
                        act_d    = $urandom_range(dly_hi, dly_lo);
                        act_sil  = (cur_w == sil_w) && (s == sil_s);
                        act_flag = (cur_w >= 0 && cur_w < NW) ? flag_tbl[s][cur_w] : 1'b0;
                    end
                end
                exp_buf = act_on ? cls_rd_addr[act_s*ADDR_W +: ADDR_W] : '0;
                if (buf_rd_addr !== exp_buf) buf_err++;
                if (hit_valid) begin
                    obs_hx.push_back(int'(hit_x));
                    obs_hy.push_back(int'(hit_y));
                    obs_wb.push_back(int'(win_base));
                    if (int'(win_base) != int'(hit_y) * 160 + int'(hit_x)) hit_wb_err++;
                end
                if (frame_done) n_fd++;
                cls_done = '0;
                cls_flag = '0;
                act_end  = 1'b0;
                if (act_on) begin
                    if (!act_sil && wcnt == act_d) begin
                        cls_done[act_s] = 1'b1;
                        cls_flag[act_s] = act_flag;
                        act_end = 1'b1;
                    end else if (act_sil && wcnt == 255) begin
                        act_end = 1'b1;
                    end else if (spur_en && $urandom_range(3, 0) == 0) begin
                        cls_done[1-act_s] = 1'b1;
                        cls_flag[1-act_s] = 1'($urandom);
                    end
                    wcnt++;
                end
                cls_rd_addr = (NUM_CLS*ADDR_W)'($urandom);
                if (act_end) act_on = 1'b0;
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"},        32'(busy), 0);
        check({tag, "_frame_done"},  32'(frame_done), 0);
        check({tag, "_cls_start"},   32'(cls_start), 0);
        check({tag, "_buf_rd_addr"}, 32'(buf_rd_addr), 0);
        check({tag, "_win_base"},    32'(win_base), 0);
        check({tag, "_hit_valid"},   32'(hit_valid), 0);
        check({tag, "_hit_x"},       32'(hit_x), 0);
        check({tag, "_hit_y"},       32'(hit_y), 0);
        check({tag, "_hit_count"},   32'(hit_count), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    task automatic start_frame(input string tag);
        widx = 0; n_start0 = 0; n_start1 = 0; n_fd = 0;
        order_err = 0; buf_err = 0; proto_err = 0; hit_wb_err = 0;
        obs_hx.delete(); obs_hy.delete(); obs_wb.delete();
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        check({tag, "_lat1_start"}, 32'(cls_start), 0);
        check({tag, "_busy_on"},    32'(busy), 1);
        check({tag, "_cnt_clr"},    32'(hit_count), 0);
        @(negedge clk);
        check({tag, "_lat2_start"}, 32'(cls_start), 1);
    endtask

    task automatic run_frame(input string tag, input int repulse_at);
        int exp_hx[$], exp_hy[$];
        int exp_s1, mism;
        bit exp_to, f0, f1, runs1, got;
        exp_s1 = 0; exp_to = 1'b0;
        for (int k = 0; k < NW; k++) begin
            f0    = flag_tbl[0][k] && !(sil_w == k && sil_s == 0);
            f1    = flag_tbl[1][k] && !(sil_w == k && sil_s == 1);
            runs1 = EARLY ? f0 : 1'b1;
            if (runs1) exp_s1++;
            if (sil_w == k && (sil_s == 0 || runs1)) exp_to = 1'b1;
            if (f0 && f1) begin
                exp_hx.push_back(wx(k));
                exp_hy.push_back(wy(k));
            end
        end
        start_frame(tag);
        got = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            frame_ready = (i == repulse_at);
            if (frame_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        frame_ready = 1'b0;
        check({tag, "_frame_done_seen"}, 32'(got), 1);
        repeat (4) @(negedge clk);
        check({tag, "_frame_done_cnt"}, n_fd, 1);
        check({tag, "_busy_off"},       32'(busy), 0);
        check({tag, "_hit_count"},      32'(hit_count), exp_hx.size());
        check({tag, "_hits_seen"},      obs_hx.size(), exp_hx.size());
        mism = 0;
        for (int i = 0; i < obs_hx.size() && i < exp_hx.size(); i++) begin
            if (obs_hx[i] != exp_hx[i] || obs_hy[i] != exp_hy[i]) mism++;
        end
        check({tag, "_hit_order"},      mism, 0);
        check({tag, "_hit_win_base"},   hit_wb_err, 0);
        check({tag, "_stage0_starts"},  n_start0, NW);
        check({tag, "_stage1_starts"},  n_start1, exp_s1);
        check({tag, "_window_order"},   order_err, 0);
        check({tag, "_buf_rd_addr"},    buf_err, 0);
        check({tag, "_start_protocol"}, proto_err, 0);
        check({tag, "_timeout_err"},    32'(timeout_err), 32'(exp_to));
        if (exp_hx.size() > 0) begin
            check({tag, "_last_hit_x"}, 32'(hit_x), exp_hx[$]);
            check({tag, "_last_hit_y"}, 32'(hit_y), exp_hy[$]);
        end
    endtask

    initial begin : main
        int s0_snap;
        rst = 1'b1;
        frame_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // all stages pass, 10-cycle classifier latency
        for (int k = 0; k < NW; k++) begin flag_tbl[0][k] = 1'b1; flag_tbl[1][k] = 1'b1; end
        dly_lo = 10; dly_hi = 10; spur_en = 1'b0; sil_w = -1;
        run_frame("allpass", -1);

        // stage 0 fails everywhere, spurious done from the idle stage
        for (int k = 0; k < NW; k++) begin flag_tbl[0][k] = 1'b0; flag_tbl[1][k] = 1'($urandom); end
        dly_lo = 1; dly_hi = 3; spur_en = 1'b1;
        run_frame("s0fail", -1);

        // stage 1 silent at window 0
        for (int k = 0; k < NW; k++) begin flag_tbl[0][k] = 1'b1; flag_tbl[1][k] = 1'b1; end
        dly_lo = 1; dly_hi = 2; spur_en = 1'b0; sil_w = 0; sil_s = 1;
        run_frame("timeout", -1);

        // reset in the middle of a sweep
        sil_w = -1;
        start_frame("rstmid");
        repeat (500) @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rstmid");
        rst = 1'b0;
        n_fd = 0;
        s0_snap = n_start0;
        repeat (300) @(negedge clk);
        check("rstmid_no_frame_done", n_fd, 0);
        check("rstmid_no_restart",    n_start0, s0_snap);
        check("rstmid_idle_busy",     32'(busy), 0);

        // random flags and latencies, spurious dones, frame_ready re-pulsed mid-sweep
        for (int k = 0; k < NW; k++) begin
            flag_tbl[0][k] = ($urandom_range(9, 0) < 7);
            flag_tbl[1][k] = ($urandom_range(9, 0) < 7);
        end
        dly_lo = 1; dly_hi = 4; spur_en = 1'b1;
        run_frame("random", 1500);

        // single passing window at x=40, y=20
        for (int k = 0; k < NW; k++) begin flag_tbl[0][k] = (k == 185); flag_tbl[1][k] = 1'($urandom); end
        flag_tbl[1][185] = 1'b1;
        dly_lo = 1; dly_hi = 2; spur_en = 1'b0;
        run_frame("spot", -1);
        check("spot_win_base", (obs_wb.size() > 0) ? 32'(obs_wb[0]) : 32'hFFFF_FFFF, 3240);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
